core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
- Multicycle control sequencer for the RV32I core: fetches an instruction over the instruction-memory handshake, latches it into the IR, then steps the shared datapath through execute, memory and writeback.
- Drives the select and write-enable lines for the ALU, PC, register file and data-memory port.
- Consumes the opcode from the latched IR; the immediate generator and ALU remain combinational slaves.
- One instruction is in flight at a time; there is no overlap.

Parameters:
- RESET_PC, 32'h0000_0000, value presented on reset_pc and loaded when pc_sel=3.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request at the current PC
- imem_req_ready  in  1  fetch request accepted
- imem_rsp_valid  in  1  instruction word valid on inst
- inst  in  32  instruction word; equals IR after the IR load
- ir_we  out  1  load IR from the imem response
- branch_taken  in  1  comparator result for the current B-type instruction
- alu_a_sel  out  2  ALU operand A: 0=rs1, 1=pc, 2=zero
- alu_b_sel  out  1  ALU operand B: 0=rs2, 1=immed
- pc_we  out  1  PC update strobe
- pc_sel  out  2  next PC: 0=pc+4, 1=alu result, 2=alu result & ~1, 3=reset_pc
- reset_pc  out  32  constant RESET_PC
- dmem_req_valid  out  1  load/store request
- dmem_req_ready  in  1  data request accepted
- dmem_rsp_valid  in  1  load data valid / store complete
- dmem_we  out  1  1=store; held with dmem_req_valid
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  writeback source: 0=alu, 1=mem, 2=pc+4
- halted  out  1  sticky, set after an illegal opcode
- cycle_count  out  32  see Optional Feature
- instret_count  out  32  see Optional Feature

Behaviour:
States and transitions:
- RESET_PC (1 cycle): pc_we=1, pc_sel=3 → FETCH_REQ.
- FETCH_REQ: imem_req_valid=1.
  - ready=1 → FETCH_WAIT; otherwise hold.
  - valid must not drop before ready.
- FETCH_WAIT: wait for imem_rsp_valid. On valid: ir_we=1 → DECODE. A response in the same cycle as acceptance is not allowed; the response arrives at least 1 cycle later.
- DECODE (1 cycle): classify inst[6:0].
  - LOAD, STORE, OP_IMMED, OP, LUI, AUIPC, JAL, JALR, BRANCH, MISC_MEM → EXEC.
  - SYSTEM or any other opcode → HALT.
- EXEC (1 cycle): operand selects by class.
  - OP: a=0, b=0.
  - OP_IMMED, LOAD, STORE, JALR: a=0, b=1.
  - LUI: a=2, b=1.
  - AUIPC, JAL, BRANCH: a=1, b=1.
  - MISC_MEM: no operation.
  - Next state: LOAD/STORE → MEM_REQ; all others → WB.
- MEM_REQ: dmem_req_valid=1; dmem_we=1 for STORE. ready → MEM_WAIT; otherwise hold with stable outputs.
- MEM_WAIT: dmem_rsp_valid → WB.
- WB (1 cycle): pc_we=1; rf_we=1 for LOAD, OP, OP_IMMED, LUI, AUIPC, JAL, JALR.
  - wb_sel: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - pc_sel: 1 for JAL; 2 for JALR; 1 for BRANCH with branch_taken=1; 0 otherwise (including STORE and MISC_MEM).
  - ALU selects are held from EXEC. → FETCH_REQ.
- HALT: absorbing; halted=1; all strobes 0. Left only by rst.

Outputs and timing:
- Strobes (ir_we, pc_we, rf_we) are single-cycle pulses, decoded from the registered state only (Moore). Exception: ir_we depends on imem_rsp_valid in FETCH_WAIT.
- Reset: state=RESET_PC on the first cycle after rst deasserts. While rst=1: every output is 0 except reset_pc; halted=0; counters=0.
- Reset during a pending imem/dmem transaction abandons it. The bench's memory models also reset.
- Minimum latency with zero-wait memories: ALU/branch/jump 5 cycles (FETCH_REQ..WB); LOAD/STORE 7 cycles.
- branch_taken is sampled only in WB.

Optional Feature:
- Macro CORE_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_count increments every cycle when not in reset and not halted.
  - instret_count increments on each WB cycle.
  - Both wrap at 2^32 to 0 and clear on rst.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset, then release with zero-wait imem: cycle 0 pc_we=1/pc_sel=3; cycle 1 imem_req_valid=1; reset_pc=RESET_PC.
- addi x1,x0,5 (32'h00500093), zero-wait: ir_we in FETCH_WAIT; EXEC shows a=0, b=1; WB shows rf_we=1, wb_sel=0, pc_sel=0; instruction takes exactly 5 cycles.
- lw (32'h0000a103) with dmem_req_ready low 3 cycles and response delayed 2: dmem_req_valid held 4 cycles with dmem_we=0, then WB with wb_sel=1, rf_we=1.
- beq (32'h00208463): branch_taken=1 gives pc_sel=1 and rf_we=0; repeat with branch_taken=0, which gives pc_sel=0.
- Illegal opcode 32'hFFFFFFFF: DECODE → HALT; halted=1 held 20 cycles; no imem_req_valid; rst clears halted and restarts at RESET_PC.
- With CORE_CTRL_PERF_CNT_EN: 3 addi instructions, zero-wait, counted from reset release → instret_count=3, cycle_count=16; assert rst mid-FETCH_WAIT → both counters 0 and FSM in RESET_PC.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// Multicycle RV32I control sequencer, one instruction in flight; optional perf counters under CORE_CTRL_PERF_CNT_EN.
// Latency 5 cycles ALU/branch/jump, 7 load/store at zero wait; stalls in FETCH_REQ/MEM_REQ until ready, waits for responses.
module core_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] inst,
  output logic        ir_we,
  input  logic        branch_taken,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] reset_pc,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMMED = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [3:0] {
    S_RESET_PC,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL,
    C_LOAD,
    C_STORE,
    C_OP_IMMED,
    C_OP,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BRANCH,
    C_MISC_MEM
  } iclass_t;

  state_t  state, state_nxt;
  iclass_t cls, dec_cls;

  logic [1:0] cls_a_sel;
  logic       cls_b_sel;
  logic       cls_rf_we;
  logic [1:0] cls_wb_sel;
  logic [1:0] cls_pc_sel;

  // Only the opcode field steers the sequencer; the rest of the IR feeds the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:7];

  assign reset_pc = RESET_PC;

  always_comb begin
    dec_cls = C_ILLEGAL;
    case (inst[6:0])
      OPC_LOAD:     dec_cls = C_LOAD;
      OPC_STORE:    dec_cls = C_STORE;
      OPC_OP_IMMED: dec_cls = C_OP_IMMED;
      OPC_OP:       dec_cls = C_OP;
      OPC_LUI:      dec_cls = C_LUI;
      OPC_AUIPC:    dec_cls = C_AUIPC;
      OPC_JAL:      dec_cls = C_JAL;
      OPC_JALR:     dec_cls = C_JALR;
      OPC_BRANCH:   dec_cls = C_BRANCH;
      OPC_MISC_MEM: dec_cls = C_MISC_MEM;
      default:      dec_cls = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET_PC;
      cls   <= C_ILLEGAL;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        cls <= dec_cls;
      end
    end
  end

  // Per-class datapath controls; EXEC and WB both read these so selects stay held into WB.
  always_comb begin
    cls_a_sel  = 2'd0;
    cls_b_sel  = 1'b0;
    cls_rf_we  = 1'b0;
    cls_wb_sel = 2'd0;
    cls_pc_sel = 2'd0;
    case (cls)
      C_OP: begin
        cls_rf_we = 1'b1;
      end
      C_OP_IMMED: begin
        cls_b_sel = 1'b1;
        cls_rf_we = 1'b1;
      end
      C_LOAD: begin
        cls_b_sel  = 1'b1;
        cls_rf_we  = 1'b1;
        cls_wb_sel = 2'd1;
      end
      C_STORE: begin
        cls_b_sel = 1'b1;
      end
      C_LUI: begin
        cls_a_sel = 2'd2;
        cls_b_sel = 1'b1;
        cls_rf_we = 1'b1;
      end
      C_AUIPC: begin
        cls_a_sel = 2'd1;
        cls_b_sel = 1'b1;
        cls_rf_we = 1'b1;
      end
      C_JAL: begin
        cls_a_sel  = 2'd1;
        cls_b_sel  = 1'b1;
        cls_rf_we  = 1'b1;
        cls_wb_sel = 2'd2;
        cls_pc_sel = 2'd1;
      end
      C_JALR: begin
        cls_b_sel  = 1'b1;
        cls_rf_we  = 1'b1;
        cls_wb_sel = 2'd2;
        cls_pc_sel = 2'd2;
      end
      C_BRANCH: begin
        cls_a_sel  = 2'd1;
        cls_b_sel  = 1'b1;
        cls_pc_sel = branch_taken ? 2'd1 : 2'd0;
      end
      default: begin
        cls_a_sel = 2'd0;
      end
    endcase
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    ir_we          = 1'b0;
    alu_a_sel      = 2'd0;
    alu_b_sel      = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 2'd0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    rf_we          = 1'b0;
    wb_sel         = 2'd0;
    halted         = 1'b0;
    case (state)
      S_RESET_PC: begin
        pc_we     = 1'b1;
        pc_sel    = 2'd3;
        state_nxt = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_nxt = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = (dec_cls == C_ILLEGAL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_a_sel = cls_a_sel;
        alu_b_sel = cls_b_sel;
        state_nxt = (cls == C_LOAD || cls == C_STORE) ? S_MEM_REQ : S_WB;
      end
      S_MEM_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_we        = (cls == C_STORE);
        if (dmem_req_ready) begin
          state_nxt = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        alu_a_sel = cls_a_sel;
        alu_b_sel = cls_b_sel;
        pc_we     = 1'b1;
        pc_sel    = cls_pc_sel;
        rf_we     = cls_rf_we;
        wb_sel    = cls_wb_sel;
        state_nxt = S_FETCH_REQ;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_RESET_PC;
      end
    endcase
    // Outputs are forced quiet while reset is held, whatever the state register shows.
    if (rst) begin
      imem_req_valid = 1'b0;
      ir_we          = 1'b0;
      alu_a_sel      = 2'd0;
      alu_b_sel      = 1'b0;
      pc_we          = 1'b0;
      pc_sel         = 2'd0;
      dmem_req_valid = 1'b0;
      dmem_we        = 1'b0;
      rf_we          = 1'b0;
      wb_sel         = 2'd0;
      halted         = 1'b0;
    end
  end

`ifdef CORE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      if (state != S_HALT) begin
        cycle_q <= cycle_q + 32'h1;
      end
      if (state == S_WB) begin
        instret_q <= instret_q + 32'h1;
      end
    end
  end

  assign cycle_count   = rst ? 32'h0 : cycle_q;
  assign instret_count = rst ? 32'h0 : instret_q;
`else
  assign cycle_count   = 32'h0;
  assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Bench for core_ctrl_fsm: builds an expected per-cycle trace from the instruction rules, then replays it.
module tb_core_ctrl_fsm;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
`ifdef CORE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        irv;
    logic        irwe;
    logic [1:0]  a;
    logic        b;
    logic        pcwe;
    logic [1:0]  pcsel;
    logic        drv;
    logic        dwe;
    logic        rfwe;
    logic [1:0]  wbsel;
    logic        halted;
    logic [31:0] rpc;
    logic [31:0] cyc;
    logic [31:0] ret;
  } out_t;

  typedef struct {
    logic        rst;
    logic        iready;
    logic        ivalid;
    logic [31:0] inst;
    logic        bt;
    logic        dready;
    logic        dvalid;
    logic        chk_alu;
    logic        chk_pc;
    logic        chk_wb;
    logic        chk_dwe;
    logic        is_wb;
    out_t        e;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] inst;
  logic        ir_we, branch_taken;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel, pc_we;
  logic [1:0]  pc_sel;
  logic [31:0] reset_pc;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid, dmem_we, rf_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [31:0] cycle_count, instret_count;

  core_ctrl_fsm #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .inst(inst), .ir_we(ir_we),
    .branch_taken(branch_taken), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .reset_pc(reset_pc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_we(dmem_we), .rf_we(rf_we),
    .wb_sel(wb_sel), .halted(halted),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nfail = 0;
  logic [31:0] mdl_cyc = 32'h0;
  logic [31:0] mdl_ret = 32'h0;
  logic [31:0] held_inst = 32'h0;
  rec_t        q[$];

  function automatic rec_t blank();
    rec_t r;
    r.rst = 1'b0; r.iready = 1'b0; r.ivalid = 1'b0; r.inst = held_inst;
    r.bt = 1'($urandom_range(0, 1)); r.dready = 1'b0; r.dvalid = 1'b0;
    r.chk_alu = 1'b0; r.chk_pc = 1'b0; r.chk_wb = 1'b0; r.chk_dwe = 1'b0; r.is_wb = 1'b0;
    r.e = '0;
    r.e.rpc = RST_PC;
    return r;
  endfunction

  // Counters: cycles count everywhere outside reset and halt; retired count steps after each WB.
  task automatic push(input rec_t r);
    if (r.rst) begin
      mdl_cyc = 32'h0;
      mdl_ret = 32'h0;
    end
    r.e.cyc = PERF ? mdl_cyc : 32'h0;
    r.e.ret = PERF ? mdl_ret : 32'h0;
    if (!r.rst && !r.e.halted) mdl_cyc = mdl_cyc + 32'h1;
    if (r.is_wb) mdl_ret = mdl_ret + 32'h1;
    q.push_back(r);
  endtask

  task automatic do_reset(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = blank();
      r.rst = 1'b1;
      r.chk_alu = 1'b1; r.chk_pc = 1'b1; r.chk_wb = 1'b1; r.chk_dwe = 1'b1;
      push(r);
    end
    r = blank();
    r.e.pcwe = 1'b1; r.e.pcsel = 2'd3; r.chk_pc = 1'b1;
    push(r);
  endtask

  task automatic fetch(input int r1, input int d1, input logic [31:0] iw, input bit deliver);
    rec_t r;
    held_inst = $urandom;
    for (int i = 0; i < r1; i++) begin
      r = blank(); r.e.irv = 1'b1; push(r);
    end
    r = blank(); r.iready = 1'b1; r.e.irv = 1'b1; push(r);
    for (int i = 0; i < d1 - 1; i++) push(blank());
    if (deliver) begin
      held_inst = iw;
      r = blank(); r.ivalid = 1'b1; r.e.irwe = 1'b1; push(r);
    end
  endtask

  task automatic do_instr(input logic [31:0] iw, input int r1, input int d1, input int r2,
                          input int d2, input int bt, input int hcyc, output int ncyc);
    rec_t       r;
    int         n0;
    bit         legal, mem, store, use_alu, rf;
    logic [1:0] a, wb, ps;
    logic       b;
    n0 = q.size();
    legal = 1; mem = 0; store = 0; use_alu = 1; rf = 1;
    a = 2'd0; b = 1'b1; wb = 2'd0; ps = 2'd0;
    case (iw[6:0])
      7'h03: begin mem = 1; wb = 2'd1; end
      7'h23: begin mem = 1; store = 1; rf = 0; end
      7'h13: b = 1'b1;
      7'h33: b = 1'b0;
      7'h37: a = 2'd2;
      7'h17: a = 2'd1;
      7'h6f: begin a = 2'd1; wb = 2'd2; ps = 2'd1; end
      7'h67: begin wb = 2'd2; ps = 2'd2; end
      7'h63: begin a = 2'd1; rf = 0; end
      7'h0f: begin use_alu = 0; rf = 0; end
      default: legal = 0;
    endcase
    fetch(r1, d1, iw, 1'b1);
    push(blank());
    if (!legal) begin
      for (int i = 0; i < hcyc; i++) begin
        r = blank(); r.e.halted = 1'b1; push(r);
      end
    end else begin
      r = blank(); r.e.a = a; r.e.b = b; r.chk_alu = use_alu; push(r);
      if (mem) begin
        for (int i = 0; i <= r2; i++) begin
          r = blank(); r.e.drv = 1'b1; r.e.dwe = store; r.chk_dwe = 1'b1;
          r.dready = (i == r2); push(r);
        end
        for (int i = 0; i < d2 - 1; i++) push(blank());
        r = blank(); r.dvalid = 1'b1; push(r);
      end
      r = blank();
      if (bt >= 0) r.bt = 1'(bt);
      r.e.pcwe = 1'b1;
      r.e.pcsel = (iw[6:0] == 7'h63) ? {1'b0, r.bt} : ps;
      r.e.rfwe = rf; r.e.wbsel = wb; r.e.a = a; r.e.b = b;
      r.chk_alu = use_alu; r.chk_pc = 1'b1; r.chk_wb = 1'b1; r.is_wb = 1'b1;
      push(r);
    end
    ncyc = q.size() - n0;
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic cmp(input rec_t r, input int idx);
    out_t act, exp;
    act = {imem_req_valid, ir_we, alu_a_sel, alu_b_sel, pc_we, pc_sel, dmem_req_valid,
           dmem_we, rf_we, wb_sel, halted, reset_pc, cycle_count, instret_count};
    exp = r.e;
    if (!r.chk_alu) begin act.a = 2'd0; act.b = 1'b0; exp.a = 2'd0; exp.b = 1'b0; end
    if (!r.chk_pc)  begin act.pcsel = 2'd0; exp.pcsel = 2'd0; end
    if (!r.chk_wb)  begin act.wbsel = 2'd0; exp.wbsel = 2'd0; end
    if (!r.chk_dwe) begin act.dwe = 1'b0; exp.dwe = 1'b0; end
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL cycle %0d outputs got %h want %h", idx, act, exp);
    end
  endtask

  initial begin
    int          n;
    logic [31:0] rnd;
    logic [6:0]  ops[10];
    ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h0f};
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst = 32'h0;
    branch_taken = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;

    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      do_instr(32'h00500093, 0, 1, 0, 0, -1, 0, n);
      pin("addi_len", 32'(n), 32'd5);
    end
    pin("model_cycles_3addi", mdl_cyc, 32'd16);
    pin("model_instret_3addi", mdl_ret, 32'd3);
    do_instr(32'h0000a103, 0, 1, 3, 2, -1, 0, n);
    pin("lw_len", 32'(n), 32'd11);
    do_instr(32'h00208463, 0, 1, 0, 0, 1, 0, n);
    pin("beq_taken_pcsel", 32'(q[q.size() - 1].e.pcsel), 32'd1);
    pin("beq_taken_rfwe", 32'(q[q.size() - 1].e.rfwe), 32'd0);
    do_instr(32'h00208463, 0, 1, 0, 0, 0, 0, n);
    pin("beq_not_taken_pcsel", 32'(q[q.size() - 1].e.pcsel), 32'd0);
    do_instr(32'h0020a223, 0, 1, 0, 1, -1, 0, n);
    pin("sw_len", 32'(n), 32'd7);

    for (int k = 0; k < 40; k++) begin
      rnd = $urandom;
      do_instr({rnd[31:7], ops[$urandom_range(0, 9)]}, $urandom_range(0, 3), $urandom_range(1, 3),
               $urandom_range(0, 3), $urandom_range(1, 3), -1, 0, n);
    end

    fetch(1, 2, 32'h0, 1'b0);
    do_reset(2);
    do_instr(32'h00500093, 0, 1, 0, 0, -1, 0, n);
    do_instr(32'hFFFFFFFF, 0, 1, 0, 0, -1, 20, n);
    pin("illegal_len", 32'(n), 32'd23);
    do_reset(2);
    do_instr(32'h00500093, 0, 1, 0, 0, -1, 0, n);
    do_instr(32'h00000073, 1, 2, 0, 0, -1, 5, n);
    do_reset(1);
    do_instr(32'h123450b7, 2, 3, 0, 0, -1, 0, n);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst = q[i].rst;
      imem_req_ready = q[i].iready;
      imem_rsp_valid = q[i].ivalid;
      inst = q[i].inst;
      branch_taken = q[i].bt;
      dmem_req_ready = q[i].dready;
      dmem_rsp_valid = q[i].dvalid;
      @(negedge clk);
      cmp(q[i], i);
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
